// File: rtl/rr_mux8_collector.sv
// rr_mux8_collector: 8:1 round-robin valid/ready collector with registered tagged output; RR_MUX_CNT_EN adds xfer_cnt
module rr_mux8_collector #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        ch_valid,
  input  logic [8*DATA_W-1:0] ch_data,
  output logic [7:0]        ch_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        out_sel,
  input  logic              out_ready
`ifdef RR_MUX_CNT_EN
  ,
  output logic [15:0]       xfer_cnt
`endif
);
  logic [2:0] ptr, g, idx;
  logic load, any;
  always_comb begin
    g = ptr;
    idx = ptr;
    for (int k = 7; k >= 0; k--) begin
      idx = ptr + 3'(k);
      g = ch_valid[idx] ? idx : g;
    end
    load = !out_valid | out_ready;
    any = |ch_valid;
    ch_ready = (!rst && load && any) ? 8'd1 << g : 8'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_sel <= 3'd0;
      ptr <= 3'd0;
    end else if (load) begin
      out_valid <= any;
      if (any) begin
        out_data <= ch_data[g*DATA_W +: DATA_W];
        out_sel <= g;
        ptr <= g + 3'd1;
      end
    end
  end
`ifdef RR_MUX_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) xfer_cnt <= 16'd0;
    else if (out_valid && out_ready) xfer_cnt <= xfer_cnt + 16'd1;
  end
`endif
endmodule
